// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bundle for serial_subtractor
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, borrow
   );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
// The borrow recirculates through br_q; result and final borrow are registered at the MSB edge.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_subtractor_if.slave   sub
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_sr_q,   a_sr_d;
   logic [WIDTH-1:0] b_sr_q,   b_sr_d;
   logic [WIDTH-1:0] d_sr_q,   d_sr_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             br_q,     br_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q,    cnt_d;

   logic             x, y, z;
   logic             cell_d, cell_b;
   logic [WIDTH-1:0] d_next;

   assign x      = a_sr_q[0];
   assign y      = b_sr_q[0];
   assign z      = br_q;
   assign cell_d = x ^ y ^ z;
   assign cell_b = (~x & y) | (~(x ^ y) & z);
   assign d_next = {cell_d, d_sr_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      d_sr_d   = d_sr_q;
      diff_d   = diff_q;
      br_d     = br_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (sub.start) begin
               a_sr_d  = sub.a;
               b_sr_d  = sub.b;
               br_d    = sub.bin;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            d_sr_d = d_next;
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            br_d   = cell_b;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               diff_d   = d_next;
               borrow_d = cell_b;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         d_sr_q   <= '0;
         diff_q   <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         d_sr_q   <= d_sr_d;
         diff_q   <= diff_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
      end
   end

   // Handshake outputs are pure decodes of the registered state.
   assign sub.busy   = (state_q == S_SHIFT);
   assign sub.done   = (state_q == S_DONE);
   assign sub.diff   = diff_q;
   assign sub.borrow = borrow_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit unsigned subtractor that computes `a - b - bin` one bit per clock, LSB first. It reuses the full-subtractor cell function: difference `D = x^y^z`, borrow `B = (~x&y) | (~(x^y)&z)`. The block sits directly downstream of the combinational full-subtractor stage. It sequences operand bits into that cell, recirculates the borrow through a register, and assembles the serial difference bits into a parallel result with a start/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Must be at least 2.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Request a subtraction. Sampled only in IDLE.
- `a`: input, WIDTH bits. Minuend, captured on the accepting edge.
- `b`: input, WIDTH bits. Subtrahend, captured on the accepting edge.
- `bin`: input, 1 bit. Borrow-in, captured on the accepting edge.
- `busy`: output, 1 bit. High while in SHIFT.
- `done`: output, 1 bit. One-cycle pulse; result valid.
- `diff`: output, WIDTH bits. Registered result, `(a - b - bin) mod 2^WIDTH`.
- `borrow`: output, 1 bit. Registered final borrow; 1 iff `a < b + bin` (unsigned).

## Operation
- Internal state:
  - shift registers `a_sr` and `b_sr` (WIDTH bits each);
  - assembly register `d_sr` (WIDTH bits);
  - borrow register `br` (1 bit);
  - bit counter `cnt` (`$clog2(WIDTH)` bits);
  - FSM with states IDLE, SHIFT, DONE.
- IDLE:
  - If `start` is 1 on an edge, load `a_sr=a`, `b_sr=b`, `br=bin`, `cnt=0`, and go to SHIFT.
  - Otherwise hold.
- SHIFT, on each edge:
  - Form `x=a_sr[0]`, `y=b_sr[0]`, `z=br`.
  - Compute `D` and `B` with the full-subtractor equations above.
  - Update `d_sr <= {D, d_sr[WIDTH-1:1]}`, `a_sr >>= 1`, `b_sr >>= 1`, `br <= B`, `cnt <= cnt+1`.
  - When `cnt == WIDTH-1`, that edge processes the MSB. On the same edge:
    - load `diff <= {D, d_sr[WIDTH-1:1]}` and `borrow <= B`;
    - go to DONE.
- DONE: `done=1` for exactly one cycle. The next edge returns to IDLE unconditionally.
- `start` in SHIFT or DONE is ignored. It is not queued. Operand changes after the accepting edge have no effect.
- `diff` and `borrow` hold their value from the DONE entry edge until the next DONE entry edge. A new start does not clear them.
- `busy` and `done` decode from state: `busy = (state==SHIFT)`, `done = (state==DONE)`. Both are glitch-free registered-state decodes.
- No combinational path from any input to any output.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - State goes to IDLE immediately, without waiting for a clock edge.
  - `busy=0`, `done=0`, `diff=0`, `borrow=0`.
  - All internal registers clear to 0.
- Reset mid-SHIFT or mid-DONE aborts the operation. No `done` pulse follows.
- Release of reset: the first edge with `rst_n=1` may accept `start`.
- Latency, with `start` accepted at edge k:
  - `busy` is high after edge k through edge k+WIDTH.
  - `diff`, `borrow` and `done` update at edge k+WIDTH.
  - `done` is high for the cycle between edges k+WIDTH and k+WIDTH+1.
- Throughput: the earliest next accepting edge is k+WIDTH+2, so one result every WIDTH+2 cycles.
- `busy` and `done` are never high together. `busy` is low in the `done` cycle.

## Test plan
- Reset:
  - Assert `rst_n=0` with no clock running: `busy`, `done`, `diff` and `borrow` are all 0.
  - Release reset and hold `start=0` for 20 cycles: all outputs stay 0.
- Basic subtraction, WIDTH=8, `a=0x05`, `b=0x03`, `bin=0`, start at edge k:
  - `busy` is high for 8 cycles.
  - `done` pulses once after edge k+8.
  - `diff=0x02`, `borrow=0`.
- Wrap and borrow:
  - `a=0x00`, `b=0x01`, `bin=0` gives `diff=0xFF`, `borrow=1`.
  - `a=0x80`, `b=0x7F`, `bin=1` gives `diff=0x00`, `borrow=0`.
  - `a=0x10`, `b=0x10`, `bin=1` gives `diff=0xFF`, `borrow=1`.
- Start and operand changes during an operation:
  - Hold `start=1` continuously and change `a`/`b` every cycle during SHIFT and DONE.
  - The result reflects the operands captured at the accepting edge.
  - The next accept occurs exactly at edge k+10.
- Reset mid-operation:
  - Drop `rst_n` 4 cycles into SHIFT: outputs go to 0 asynchronously and no `done` appears.
  - After release, `a=0xA5`, `b=0x5A`, `bin=0` gives `diff=0x4B`, `borrow=0`.
- Exhaustive check at WIDTH=3:
  - Apply all 128 combinations of `a`, `b` and `bin`, each back-to-back.
  - For every case, `{borrow,diff}` equals `(a - b - bin) mod 16`, with `borrow` as bit 3.
